// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared FSM state type and default sizes for fifo_rd_arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational masked round-robin selector
// Ports: req   - request vector, one bit per requester
//        ptr   - highest-priority index for this pick
//        found - at least one request is set
//        idx   - first set request at or above ptr, else lowest set request
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    logic          hi_found;
    logic [PW-1:0] hi_idx;

    // Scanning downwards leaves the lowest matching index in each result;
    // the masked (>= ptr) result wins, otherwise the search wraps to bit 0.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = PW'(i);
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(i);
                end
            end
        end
        if (hi_found) begin
            idx = hi_idx;
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// rtl/fifo_rd_arbiter.sv - burst round-robin read arbiter over NUM_REQ FWFT sync FIFOs
// Ports: clk, reset_n (sync, active-low)
//        i_req_valid/i_req_almostfull/i_req_data - per-FIFO status and head word
//        o_req_ready - per-FIFO pop strobe (combinational, granted FIFO only)
//        o_valid/o_data/i_ready - registered downstream stream
//        o_grant_id/o_busy - current grant and BURST indication
// Build option: FIFO_ARB_WATERMARK_EN gives almost-full requesters priority in IDLE.
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_almostfull,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_data,
    input  logic                          i_ready,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
    output logic                          o_busy
);

    localparam int GW = $clog2(NUM_REQ);

    arb_state_e            state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [7:0]            beat_q, beat_d;
    logic                  o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;

    logic                  pick_found;
    logic [GW-1:0]         pick_idx;
    logic [GW-1:0]         next_ptr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  pop;

`ifdef FIFO_ARB_WATERMARK_EN
    logic          hot_found, all_found;
    logic [GW-1:0] hot_idx, all_idx;

    rr_picker #(.N(NUM_REQ), .PW(GW)) u_pick_hot (
        .req   (i_req_valid & i_req_almostfull),
        .ptr   (rr_ptr_q),
        .found (hot_found),
        .idx   (hot_idx)
    );

    rr_picker #(.N(NUM_REQ), .PW(GW)) u_pick_all (
        .req   (i_req_valid),
        .ptr   (rr_ptr_q),
        .found (all_found),
        .idx   (all_idx)
    );

    assign pick_found = hot_found | all_found;
    assign pick_idx   = hot_found ? hot_idx : all_idx;
`else
    logic unused_almostfull;
    assign unused_almostfull = ^i_req_almostfull;

    rr_picker #(.N(NUM_REQ), .PW(GW)) u_pick (
        .req   (i_req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );
`endif

    assign next_ptr  = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign head_data = i_req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

    // Pop only when the output register is free or being drained this cycle;
    // gating with reset_n keeps the strobe quiet during a mid-burst reset.
    assign pop = reset_n && (state_q == BURST) && i_req_valid[grant_q] && (!o_valid_q || i_ready);

    always_comb begin
        o_req_ready = '0;
        if (pop) begin
            o_req_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        beat_d    = beat_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BURST;
                    grant_d = pick_idx;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (!i_req_valid[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                    beat_d   = '0;
                end else if (pop) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q + 8'd1 == 8'(MAX_BURST)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                        beat_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Output register drains independently of the FSM state.
        if (pop) begin
            o_valid_d = 1'b1;
            o_data_d  = head_data;
        end else if (i_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            beat_q    <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            beat_q    <= beat_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_data     = o_data_q;
    assign o_grant_id = grant_q;
    assign o_busy     = (state_q == BURST);

endmodule

// File: doc/fifo_rd_arbiter.md
FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of sync FIFO requesters (2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the per-requester data width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the maximum pops per grant (1..255).
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 i_req_valid  input  NUM_REQ  per-FIFO not-empty; driven by each FIFO's o_valid_m.
REQ-007 i_req_almostfull  input  NUM_REQ  per-FIFO o_almostfull.
REQ-008 i_req_data  input  NUM_REQ*DATA_WIDTH  per-FIFO head data, first-word fall-through; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 o_req_ready  output  NUM_REQ  per-FIFO pop strobe; drives each FIFO's i_ready_m.
REQ-010 o_valid  output  1  downstream data valid.
REQ-011 o_data  output  DATA_WIDTH  downstream data.
REQ-012 i_ready  input  1  downstream accept.
REQ-013 o_grant_id  output  $clog2(NUM_REQ)  index of the requester currently granted.
REQ-014 o_busy  output  1  high while a grant is active (state BURST).

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and BURST.
REQ-016 In IDLE with any i_req_valid high, the block SHALL register grant g, the first valid requester in round-robin order starting at rr_ptr, and enter BURST next cycle; no pop SHALL occur in IDLE.
REQ-017 In IDLE with no i_req_valid high, the block SHALL remain in IDLE.
REQ-018 In BURST, a pop SHALL occur when i_req_valid[g] && (!o_valid || i_ready), with o_req_ready[g]=1 combinationally in that cycle.
REQ-019 All o_req_ready bits other than g SHALL be 0, and o_req_ready SHALL be all-zero in IDLE.
REQ-020 On a pop, the block SHALL load the output register with o_data<=i_req_data[g] and o_valid<=1, giving one-cycle latency from pop to o_valid.
REQ-021 If no pop occurs and i_ready=1, the block SHALL clear o_valid; if no pop occurs and i_ready=0, o_valid and o_data SHALL hold.
REQ-022 A beat counter SHALL count pops in BURST; at the pop that makes the count equal MAX_BURST, the FSM SHALL return to IDLE next cycle.
REQ-023 If i_req_valid[g]=0 in any BURST cycle, the FSM SHALL return to IDLE next cycle with no pop in that cycle.
REQ-024 On leaving BURST, rr_ptr SHALL become (g+1) mod NUM_REQ, the beat counter SHALL clear, and the output register SHALL drain independently of state.
REQ-025 Downstream backpressure (i_ready=0 with o_valid=1) SHALL stall pops without ending the burst.
REQ-026 o_grant_id SHALL hold g from BURST entry until the next grant.
REQ-027 Each grant SHALL cost exactly one IDLE cycle of overhead, so sustained throughput is MAX_BURST/(MAX_BURST+1).

Reset
REQ-028 While reset_n=0 at a clock edge, the block SHALL set state=IDLE, rr_ptr=0, beat counter=0, o_valid=0, o_data=0, o_grant_id=0, and o_busy=0.
REQ-029 o_req_ready SHALL be 0 during the reset cycle, including mid-burst, and any buffered output word SHALL be discarded.

Configuration
REQ-030 The block SHALL support macro FIFO_ARB_WATERMARK_EN to compile watermark priority in or out.
REQ-031 With FIFO_ARB_WATERMARK_EN defined, the IDLE selection SHALL first round-robin among requesters with i_req_valid && i_req_almostfull, and fall back to all valid requesters only if none are almost full.
REQ-032 Without FIFO_ARB_WATERMARK_EN, i_req_almostfull SHALL be ignored and selection SHALL be pure round-robin.

Structure
REQ-033 Package fifo_arb_pkg SHALL hold the FSM state typedef (IDLE, BURST) and the default constants for NUM_REQ, DATA_WIDTH and MAX_BURST.
REQ-034 Sub-module rr_picker SHALL be a combinational masked round-robin selector with inputs req[NUM_REQ] and ptr and outputs found and idx; it SHALL be instantiated once, or twice when FIFO_ARB_WATERMARK_EN is defined.

Verification
REQ-035 Reset then all four requesters always valid, i_ready=1, MAX_BURST=4 -> grants 0,1,2,3,0; 4 pops each; 1 idle cycle between bursts.
REQ-036 Only requester 2 valid with 2 words -> 2 pops; at 3rd BURST cycle valid[2]=0 -> IDLE, rr_ptr=3, o_data sequence matches FIFO order.
REQ-037 i_ready=0 for 5 cycles mid-burst -> o_valid/o_data held, o_req_ready=0, beat count frozen, burst resumes without data loss or duplication.
REQ-038 reset_n=0 for one cycle during beat 2 of a burst -> next cycle state IDLE, o_valid=0, rr_ptr=0, no o_req_ready pulse in the reset cycle.
REQ-039 FIFO_ARB_WATERMARK_EN defined, rr_ptr=0, valid=4'b1111, almostfull=4'b0100 -> grant 2; same stimulus without the macro -> grant 0.
